alu6_seq_ctrl: RTL

- Sequencing front-end for the 6-bit ripple adder in the ALU.
- Accepts operation requests over a valid/ready handshake and drives the adder's x, y and c_in inputs.
- Captures the adder's sum, c_out and overflow into a result register with Z/N/C/V flags, and presents the result downstream over valid/ready.
- Performs MUL as iterative shift-add through the same adder, so the ALU needs no separate multiplier.

---
 rtl/alu6_seq_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu6_seq_ctrl.sv
// alu6_seq_ctrl
// Sequencing front-end for the ALU's external 6-bit ripple adder.
// A request (op, a, b) is accepted over in_valid/in_ready. The block then
// drives the adder's x/y/c_in and captures sum, carry and overflow into a
// result register with Z/N/C/V flags. The result is presented downstream
// over out_valid/out_ready. MUL is an iterative shift-add through the same
// adder, one partial product per cycle, so no separate multiplier is needed.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     request handshake
//   in_op                 00 ADD, 01 SUB, 10 MUL, 11 CMP
//   in_a, in_b            operands
//   add_x/add_y/add_cin   adder operand drive
//   add_sum/add_cout/add_ovf  adder results (combinational from the drive)
//   out_valid/out_ready   result handshake
//   out_result, out_flags result and {Z,N,C,V}
module alu6_seq_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    input  logic             add_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    // Index of the final shift-add step (one step per multiplier bit).
    localparam logic [2:0] LAST_ITER = 3'd5;

    logic [1:0]       state_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [2:0]       cnt_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_result_r;
    logic [3:0]       out_flags_r;

    logic [WIDTH-1:0] add_x_s;
    logic [WIDTH-1:0] add_y_s;
    logic             add_cin_s;

    // Packs {Z,N,C,V}; Z/N are taken from the value passed in, which is the
    // adder sum even for CMP (whose result register keeps operand a).
    function automatic logic [3:0] calc_flags(
        input logic [WIDTH-1:0] value,
        input logic             carry,
        input logic             ovf
    );
        calc_flags = {(value == {WIDTH{1'b0}}), value[WIDTH-1], carry, ovf};
    endfunction

    // Adder operand drive: active only in EXEC and MUL, zero otherwise.
    always_comb begin
        add_x_s   = {WIDTH{1'b0}};
        add_y_s   = {WIDTH{1'b0}};
        add_cin_s = 1'b0;
        case (state_r)
            ST_EXEC: begin
                add_x_s = a_r;
                if (op_r == OP_ADD) begin
                    add_y_s   = b_r;
                    add_cin_s = 1'b0;
                end else begin
                    // a - b as a + ~b + 1; carry out then means "no borrow".
                    add_y_s   = ~b_r;
                    add_cin_s = 1'b1;
                end
            end
            ST_MUL: begin
                add_x_s = acc_r;
                if (b_r[cnt_r]) begin
                    add_y_s = a_r << cnt_r;
                end else begin
                    add_y_s = {WIDTH{1'b0}};
                end
            end
            default: begin
                add_x_s   = {WIDTH{1'b0}};
                add_y_s   = {WIDTH{1'b0}};
                add_cin_s = 1'b0;
            end
        endcase
    end

    // Control FSM plus operand, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            op_r         <= 2'b00;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            acc_r        <= {WIDTH{1'b0}};
            cnt_r        <= 3'd0;
            out_valid_r  <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
            out_flags_r  <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r  <= in_op;
                        a_r   <= in_a;
                        b_r   <= in_b;
                        acc_r <= {WIDTH{1'b0}};
                        cnt_r <= 3'd0;
                        if (in_op == OP_MUL) begin
                            state_r <= ST_MUL;
                        end else begin
                            state_r <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (op_r == OP_CMP) begin
                        out_result_r <= a_r;
                    end else begin
                        out_result_r <= add_sum;
                    end
                    out_flags_r <= calc_flags(add_sum, add_cout, add_ovf);
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_MUL: begin
                    acc_r <= add_sum;
                    if (cnt_r == LAST_ITER) begin
                        // Product is taken straight from the final sum
                        // rather than waiting a cycle for acc_r.
                        out_result_r <= add_sum;
                        out_flags_r  <= calc_flags(add_sum, 1'b0, 1'b0);
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_r == ST_IDLE);
    assign add_x      = add_x_s;
    assign add_y      = add_y_s;
    assign add_cin    = add_cin_s;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_flags  = out_flags_r;

endmodule
